// File: rtl/sub16_80_seq.sv
// sub16_80_seq: multi-cycle wide subtractor.
// Computes Diff = A - B - Bin (mod 2^WIDTH) and the final borrow Bout.
// One SLICE-bit ripple subtract stage is reused over WIDTH/SLICE cycles,
// working from the least significant slice upwards.
//
// Handshake: start is a request that is accepted only while idle (busy=0,
// done=0); A/B/Bin are captured on that same edge. busy stays high while
// slices are processed. done is a one-cycle pulse during which Diff/Bout
// are valid. Diff/Bout then hold until the next accepted start. A start
// that arrives while busy or done is dropped, not queued.
module sub16_80_seq #(
    parameter int WIDTH = 80,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;

    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE:0]   sub_s;
    logic [SLICE-1:0] diff_s;
    logic             bo_s;

    // Select the operand slice addressed by the current slice index.
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDXW'(i)) begin
                a_s = a_q[i*SLICE +: SLICE];
                b_s = b_q[i*SLICE +: SLICE];
            end
        end
    end

    // One SLICE-bit subtract stage; the extra top bit is the borrow out
    // (it goes to 1 exactly when a_s < b_s + borrow_q).
    always_comb begin
        sub_s  = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, borrow_q};
        diff_s = sub_s[SLICE-1:0];
        bo_s   = sub_s[SLICE];
    end

    // Control FSM plus operand, borrow and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            Diff     <= '0;
            Bout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        Diff     <= '0;
                        idx      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IDXW'(i)) begin
                            Diff[i*SLICE +: SLICE] <= diff_s;
                        end
                    end
                    borrow_q <= bo_s;
                    if (idx == LAST_IDX) begin
                        Bout  <= bo_s;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags decode straight from the registered state.
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_sub16_80_seq.sv
// tb_sub16_80_seq: directed and randomized checks of sub16_80_seq against
// a plain-arithmetic reference (A - B - Bin evaluated one bit wider).
module tb_sub16_80_seq;

    localparam int W = 80;
    localparam int S = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected {Bout, Diff} per accepted operation.
    logic [W:0] exp_q[$];

    sub16_80_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (a),
        .B         (b),
        .Bin       (bin),
        .Diff      (diff),
        .Bout      (bout),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) begin
            v = (v << 32) | W'($urandom);
        end
        return v;
    endfunction

    // Reference: wide subtraction with one extra bit; top bit is the borrow.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        return r;
    endfunction

    // ---------------- driver ----------------
    // Launches one operation and follows it to completion. With hold=1,
    // start stays high and the operands keep changing during RUN.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input bit hold);
        int         busy_cnt;
        bit         got_done;
        logic [W:0] exp;
        exp_q.push_back(ref_sub(xa, xb, xc));
        @(negedge clk);
        a = xa; b = xb; bin = xc; start = 1'b1;
        @(posedge clk);                       // edge 0: accepted
        #1;
        if (!hold) start = 1'b0;
        a = rand_w(); b = rand_w(); bin = 1'($urandom_range(0, 1));
        busy_cnt = 0;
        got_done = 0;
        for (int c = 0; c < 20 && !got_done; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                check("done_latency", (W+1)'(c), (W+1)'(5));
                check("busy_with_done", (W+1)'(busy), (W+1)'(0));
                exp = exp_q.pop_front();
                check("diff", (W+1)'(diff), (W+1)'(exp[W-1:0]));
                check("bout", (W+1)'(bout), (W+1)'(exp[W]));
                start = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (hold) begin
                    a = rand_w(); b = rand_w(); bin = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!got_done) begin
            check("done_timeout", (W+1)'(0), (W+1)'(1));
            void'(exp_q.pop_front());
        end
        check("busy_cycles", (W+1)'(busy_cnt), (W+1)'(5));
        start = 1'b0;
        // One cycle later: back to idle, single done, result held.
        @(negedge clk);
        check("idle_after_done", (W+1)'({busy, done}), (W+1)'(0));
        if (got_done) begin
            check("diff_hold", {bout, diff}, ref_sub(xa, xb, xc));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   dn_cnt;
        logic [W-1:0] ones;
        ones  = '1;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bout, diff}, '0);
        check("reset_flags", (W+1)'({busy, done}), (W+1)'(0));

        // rst has priority over start on the same edge.
        start = 1'b1; a = 80'd9; b = 80'd2;
        @(negedge clk);
        check("rst_over_start", (W+1)'({busy, done}), (W+1)'(0));
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_op('0, '0, 1'b0, 0);
        do_op('0, 80'd1, 1'b0, 0);
        check("all_ones_borrow", {bout, diff}, {1'b1, ones});
        do_op(80'h80000000000000000000, 80'd1, 1'b0, 0);
        check("msb_case", {bout, diff}, {1'b0, 80'h7FFFFFFFFFFFFFFFFFFF});
        do_op(ones, ones, 1'b1, 0);
        do_op(80'd5, 80'd3, 1'b1, 0);
        check("small_case", {bout, diff}, {1'b0, 80'd1});
        do_op(80'd10, 80'd3, 1'b0, 1);
        check("hold_start_case", {bout, diff}, {1'b0, 80'd7});

        // Idle with no start: result holds.
        repeat (4) @(negedge clk);
        check("idle_hold", {bout, diff}, {1'b0, 80'd7});

        // Randomized operations, some with start held and operands churning.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            ra = rand_w();
            rb = rand_w();
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra[S-1:0] = '0;
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // Abort: rst sampled on edge 2 of an operation.
        @(negedge clk);
        a = 80'd100; b = 80'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk);                       // edge 0
        #1 start = 1'b0;
        @(posedge clk);                       // edge 1
        #1 rst = 1'b1;
        @(posedge clk);                       // edge 2
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_flags", (W+1)'({busy, done}), (W+1)'(0));
        check("abort_outputs", {bout, diff}, '0);
        dn_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) dn_cnt++;
        end
        check("no_done_after_abort", (W+1)'(dn_cnt), (W+1)'(0));

        // First start after reset is accepted.
        do_op(rand_w(), rand_w(), 1'b1, 0);

        check("scoreboard_empty", (W+1)'(exp_q.size()), (W+1)'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // done and busy are never high together.
    always @(negedge clk) begin
        if (!rst && busy && done) begin
            check("busy_done_overlap", (W+1)'(1), (W+1)'(0));
        end
    end

endmodule
